instr_prefetch_queue: RTL and testbench

//  Instruction fetch stage directly upstream of the CPU core; supplies its i_datain bus.

---
 rtl/instr_prefetch_queue.sv | 127 ++++++++++++
 tb/tb_instr_prefetch_queue.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_prefetch_queue.sv
// Sequential instruction prefetcher: one outstanding memory read, DEPTH-entry FIFO to the core.
// Optional HALT_STOP_EN stops fetching after a HALT opcode is queued.
//
// state   | meaning
// IDLE    | no read outstanding; issue one if enabled and space remains
// WAIT    | read outstanding; its response is pushed with the current fpc
// DISCARD | read outstanding but made stale by a redirect; response is dropped
module instr_prefetch_queue #(
  parameter int         DEPTH   = 4,
  parameter int         AW      = 8,
  parameter int         DW      = 16,
  parameter logic [4:0] HALT_OP = 5'b00001
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     redirect,
  input  logic [AW-1:0]            redirect_pc,
  output logic [DW-1:0]            i_datain,
  output logic [AW-1:0]            i_pc,
  output logic                     i_valid,
  input  logic                     i_ready,
  output logic                     imem_req,
  output logic [AW-1:0]            imem_addr,
  input  logic [DW-1:0]            imem_rdata,
  input  logic                     imem_rvalid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     halted
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

`ifdef HALT_STOP_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DISCARD} state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   data_mem [DEPTH];
  logic [AW-1:0]   pc_mem   [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count_q;
  logic [AW-1:0]   fpc;
  logic            halt_q;
  logic            push, pop, full, is_halt_op;

  assign full       = (count_q == CW'(DEPTH));
  assign i_valid    = (count_q != '0);
  assign pop        = i_valid && i_ready && !redirect;
  assign i_datain   = i_valid ? data_mem[rd_ptr] : '0;
  assign i_pc       = i_valid ? pc_mem[rd_ptr] : '0;
  assign imem_addr  = imem_req ? fpc : '0;
  assign count      = count_q;
  assign halted     = halt_q;
  assign is_halt_op = HALT_EN && (imem_rdata[DW-1 -: 5] == HALT_OP);

  always_comb begin
    state_d  = state_q;
    imem_req = 1'b0;
    push     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (enable && !redirect && !full && !halt_q) begin
          imem_req = 1'b1;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        // A response landing in the redirect cycle is already consumed, so no DISCARD wait.
        if (redirect) state_d = imem_rvalid ? S_IDLE : S_DISCARD;
        else if (imem_rvalid) begin
          push    = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_DISCARD: begin
        if (imem_rvalid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      fpc     <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (redirect) begin
        fpc     <= redirect_pc;
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        count_q <= '0;
        halt_q  <= 1'b0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + PW'(1);
          fpc    <= fpc + AW'(1);
          if (is_halt_op) halt_q <= 1'b1;
        end
        if (pop) rd_ptr <= rd_ptr + PW'(1);
        case ({push, pop})
          2'b10:   count_q <= count_q + CW'(1);
          2'b01:   count_q <= count_q - CW'(1);
          default: count_q <= count_q;
        endcase
      end
    end
  end

  // Storage needs no reset: entries are only visible through count_q.
  always_ff @(posedge clock) begin
    if (push) begin
      data_mem[wr_ptr] <= imem_rdata;
      pc_mem[wr_ptr]   <= fpc;
    end
  end

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Directed bench for instr_prefetch_queue with a behavioural instruction memory of
// configurable latency; halt checks adapt to whether HALT_STOP_EN is defined.
module tb_instr_prefetch_queue;

  logic        clock = 1'b0;
  logic        reset = 1'b1, enable = 1'b0, redirect = 1'b0, i_ready = 1'b0;
  logic [7:0]  redirect_pc = '0;
  logic [15:0] i_datain;
  logic [7:0]  i_pc, imem_addr;
  logic        i_valid, imem_req, halted;
  logic [15:0] imem_rdata = '0;
  logic        imem_rvalid = 1'b0;
  logic [2:0]  count;

  int total = 0;
  int bad = 0;
  int mem_lat = 1;
  bit halt_mode = 1'b0;
  int pend = 0;
  logic [7:0]  pend_addr = '0;
  logic [7:0]  req_log[$];
  logic [7:0]  pop_pc[$];
  logic [15:0] pop_data[$];

  instr_prefetch_queue dut (
    .clock(clock), .reset(reset), .enable(enable), .redirect(redirect),
    .redirect_pc(redirect_pc), .i_datain(i_datain), .i_pc(i_pc), .i_valid(i_valid),
    .i_ready(i_ready), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_rvalid(imem_rvalid), .count(count), .halted(halted)
  );

  always #5 clock = ~clock;

  function automatic logic [15:0] mem_word(input logic [7:0] a);
    if (halt_mode && a == 8'd3) return 16'h0800;
    return 16'h1000 + {8'h00, a};
  endfunction

  always @(posedge clock) begin
    imem_rvalid <= 1'b0;
    if (reset) pend <= 0;
    else if (imem_req) begin
      if (mem_lat == 1) begin
        imem_rvalid <= 1'b1;
        imem_rdata  <= mem_word(imem_addr);
      end else begin
        pend      <= mem_lat - 1;
        pend_addr <= imem_addr;
      end
    end else if (pend == 1) begin
      imem_rvalid <= 1'b1;
      imem_rdata  <= mem_word(pend_addr);
      pend        <= 0;
    end else if (pend > 1) pend <= pend - 1;
  end

  always @(posedge clock) begin
    if (!reset) begin
      if (imem_req) req_log.push_back(imem_addr);
      if (i_valid && i_ready && !redirect) begin
        pop_pc.push_back(i_pc);
        pop_data.push_back(i_datain);
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; enable = 1'b0; redirect = 1'b0; redirect_pc = '0; i_ready = 1'b0;
    mem_lat = 1; halt_mode = 1'b0;
    cycles(2);
    reset = 1'b0;
    req_log.delete(); pop_pc.delete(); pop_data.delete();
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    total++; if (count !== 3'd0) begin bad++; $display("FAIL reset_count actual=%0d required=0", count); end
    total++; if (i_valid !== 1'b0) begin bad++; $display("FAIL reset_valid actual=%b required=0", i_valid); end
    total++; if (i_datain !== 16'h0) begin bad++; $display("FAIL reset_datain actual=%h required=0000", i_datain); end
    total++; if (i_pc !== 8'h0) begin bad++; $display("FAIL reset_pc actual=%h required=00", i_pc); end
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL reset_req actual=%b required=0", imem_req); end
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL reset_halted actual=%b required=0", halted); end
  endtask

  task automatic test_fill();
    do_reset();
    enable = 1'b1;
    cycles(20);
    total++; if (req_log.size() != 4) begin bad++; $display("FAIL fill_req_count actual=%0d required=4", req_log.size()); end
    for (int i = 0; i < 4 && i < req_log.size(); i++) begin
      total++; if (req_log[i] !== 8'(i)) begin bad++; $display("FAIL fill_req_addr[%0d] actual=%h required=%h", i, req_log[i], 8'(i)); end
    end
    total++; if (count !== 3'd4) begin bad++; $display("FAIL fill_count actual=%0d required=4", count); end
    total++; if (i_valid !== 1'b1) begin bad++; $display("FAIL fill_valid actual=%b required=1", i_valid); end
    total++; if (i_datain !== 16'h1000) begin bad++; $display("FAIL fill_datain actual=%h required=1000", i_datain); end
    total++; if (i_pc !== 8'h00) begin bad++; $display("FAIL fill_pc actual=%h required=00", i_pc); end
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL fill_no_req actual=%b required=0", imem_req); end
  endtask

  task automatic test_drain();
    pop_pc.delete(); pop_data.delete();
    i_ready = 1'b1;
    repeat (30) begin
      @(negedge clock);
      total++; if (count > 3'd4) begin bad++; $display("FAIL drain_count_max actual=%0d required<=4", count); end
    end
    i_ready = 1'b0;
    total++; if (pop_data.size() < 12) begin bad++; $display("FAIL drain_pops actual=%0d required>=12", pop_data.size()); end
    for (int i = 0; i < pop_data.size(); i++) begin
      total++; if (pop_data[i] !== 16'h1000 + 16'(i)) begin bad++; $display("FAIL drain_data[%0d] actual=%h required=%h", i, pop_data[i], 16'h1000 + 16'(i)); end
      total++; if (pop_pc[i] !== 8'(i)) begin bad++; $display("FAIL drain_pc[%0d] actual=%h required=%h", i, pop_pc[i], 8'(i)); end
    end
  endtask

  task automatic test_redirect_stale();
    do_reset();
    mem_lat = 2;
    enable = 1'b1;
    @(negedge clock);
    redirect = 1'b1; redirect_pc = 8'h40;
    #1;
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL stale_req_in_redirect actual=%b required=0", imem_req); end
    @(negedge clock);
    redirect = 1'b0;
    #1;
    total++; if (count !== 3'd0) begin bad++; $display("FAIL stale_count actual=%0d required=0", count); end
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL stale_req_discard actual=%b required=0", imem_req); end
    cycles(8);
    total++; if (i_valid !== 1'b1) begin bad++; $display("FAIL stale_valid actual=%b required=1", i_valid); end
    total++; if (i_pc !== 8'h40) begin bad++; $display("FAIL stale_head_pc actual=%h required=40", i_pc); end
    total++; if (i_datain !== 16'h1040) begin bad++; $display("FAIL stale_head_data actual=%h required=1040", i_datain); end
    total++; if (req_log.size() < 2 || req_log[1] !== 8'h40) begin bad++; $display("FAIL stale_second_req actual_n=%0d required=40", req_log.size()); end
  endtask

  task automatic test_wrap_latency();
    logic [7:0] exp_seq [4];
    exp_seq = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    do_reset();
    i_ready = 1'b1; enable = 1'b1; redirect = 1'b1; redirect_pc = 8'hFE;
    #1;
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL wrap_req_in_redirect actual=%b required=0", imem_req); end
    @(negedge clock);
    redirect = 1'b0;
    #1;
    total++; if (imem_req !== 1'b1 || imem_addr !== 8'hFE) begin bad++; $display("FAIL wrap_first_req actual=%b/%h required=1/fe", imem_req, imem_addr); end
    @(negedge clock);
    total++; if (i_valid !== 1'b0) begin bad++; $display("FAIL wrap_valid_early actual=%b required=0", i_valid); end
    @(negedge clock);
    total++; if (i_valid !== 1'b1 || i_pc !== 8'hFE || i_datain !== 16'h10FE) begin bad++; $display("FAIL wrap_first_head actual=%b/%h/%h required=1/fe/10fe", i_valid, i_pc, i_datain); end
    cycles(14);
    total++; if (req_log.size() < 4 || pop_pc.size() < 4) begin bad++; $display("FAIL wrap_log_len actual=%0d/%0d required>=4", req_log.size(), pop_pc.size()); end
    for (int i = 0; i < 4 && i < req_log.size(); i++) begin
      total++; if (req_log[i] !== exp_seq[i]) begin bad++; $display("FAIL wrap_req[%0d] actual=%h required=%h", i, req_log[i], exp_seq[i]); end
    end
    for (int i = 0; i < 4 && i < pop_pc.size(); i++) begin
      total++; if (pop_pc[i] !== exp_seq[i] || pop_data[i] !== 16'h1000 + {8'h00, exp_seq[i]}) begin
        bad++; $display("FAIL wrap_pop[%0d] actual=%h/%h required=%h", i, pop_pc[i], pop_data[i], exp_seq[i]);
      end
    end
    i_ready = 1'b0;
  endtask

  task automatic test_enable_drop();
    do_reset();
    mem_lat = 2;
    enable = 1'b1;
    @(negedge clock);
    enable = 1'b0;
    cycles(10);
    total++; if (count !== 3'd1) begin bad++; $display("FAIL endrop_count actual=%0d required=1", count); end
    total++; if (i_datain !== 16'h1000 || i_pc !== 8'h00) begin bad++; $display("FAIL endrop_head actual=%h/%h required=1000/00", i_datain, i_pc); end
    total++; if (req_log.size() != 1) begin bad++; $display("FAIL endrop_req_count actual=%0d required=1", req_log.size()); end
    enable = 1'b1;
    #1;
    total++; if (imem_req !== 1'b1 || imem_addr !== 8'h01) begin bad++; $display("FAIL endrop_resume actual=%b/%h required=1/01", imem_req, imem_addr); end
    enable = 1'b0;
  endtask

  task automatic test_halt();
    do_reset();
    halt_mode = 1'b1; i_ready = 1'b1; enable = 1'b1;
    cycles(20);
`ifdef HALT_STOP_EN
    total++; if (halted !== 1'b1) begin bad++; $display("FAIL halt_set actual=%b required=1", halted); end
    total++; if (req_log.size() != 4) begin bad++; $display("FAIL halt_req_count actual=%0d required=4", req_log.size()); end
    total++; if (pop_data.size() != 4 || pop_data[3] !== 16'h0800) begin bad++; $display("FAIL halt_drain actual_n=%0d required=4 ending 0800", pop_data.size()); end
    total++; if (count !== 3'd0) begin bad++; $display("FAIL halt_count actual=%0d required=0", count); end
    redirect = 1'b1; redirect_pc = 8'h10;
    @(negedge clock);
    redirect = 1'b0;
    #1;
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL halt_clear actual=%b required=0", halted); end
    total++; if (imem_req !== 1'b1 || imem_addr !== 8'h10) begin bad++; $display("FAIL halt_resume actual=%b/%h required=1/10", imem_req, imem_addr); end
`else
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL nohalt_tied actual=%b required=0", halted); end
    total++; if (req_log.size() <= 4 || req_log[4] !== 8'h04) begin bad++; $display("FAIL nohalt_continue actual_n=%0d required addr 04 fetched", req_log.size()); end
`endif
    enable = 1'b0; i_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_redirect_stale();
    test_wrap_latency();
    test_enable_drop();
    test_halt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule
